// File: rtl/rom_arb_if.sv
// Request/response bus between the two ROM requesters and rom_arb,
// plus the ROM read port. Slave modport is the arbiter side.
interface rom_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_p0_req_valid;
  logic [ADDR_W-1:0] i_p0_req_addr;
  logic              o_p0_req_ready;
  logic              o_p0_resp_valid;
  logic              i_p0_resp_ready;
  logic [DATA_W-1:0] o_p0_resp_data;
  logic              o_p0_resp_err;

  logic              i_p1_req_valid;
  logic [ADDR_W-1:0] i_p1_req_addr;
  logic              o_p1_req_ready;
  logic              o_p1_resp_valid;
  logic              i_p1_resp_ready;
  logic [DATA_W-1:0] o_p1_resp_data;
  logic              o_p1_resp_err;

  logic              o_rom_rd_en;
  logic [ADDR_W-1:0] o_rom_rd_addr;
  logic [DATA_W-1:0] i_rom_rd_data;

  modport slave (
    input  i_p0_req_valid, i_p0_req_addr, i_p0_resp_ready,
    input  i_p1_req_valid, i_p1_req_addr, i_p1_resp_ready,
    input  i_rom_rd_data,
    output o_p0_req_ready, o_p0_resp_valid,
    output o_p0_resp_data, o_p0_resp_err,
    output o_p1_req_ready, o_p1_resp_valid,
    output o_p1_resp_data, o_p1_resp_err,
    output o_rom_rd_en, o_rom_rd_addr
  );

  modport master (
    output i_p0_req_valid, i_p0_req_addr, i_p0_resp_ready,
    output i_p1_req_valid, i_p1_req_addr, i_p1_resp_ready,
    output i_rom_rd_data,
    input  o_p0_req_ready, o_p0_resp_valid,
    input  o_p0_resp_data, o_p0_resp_err,
    input  o_p1_req_ready, o_p1_resp_valid,
    input  o_p1_resp_data, o_p1_resp_err,
    input  o_rom_rd_en, o_rom_rd_addr
  );
endinterface

// File: rtl/rom_arb.sv
// Two-port round-robin arbiter in front of a combinational ROM.
// Ports: i_sys_clk, i_sys_rst (sync, active-high), bus (rom_arb_if.slave).
module rom_arb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ROM_WORDS = 1024
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  rom_arb_if.slave   bus
);

  typedef enum logic {IDLE, RESP} state_e;

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ROM_WORDS);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              owner_rdy;
  logic              can_gnt;
  logic              gnt0, gnt1, gnt;
  logic [ADDR_W-1:0] gaddr;
  logic [ADDR_W-1:0] gword;
  logic              bad;
  logic              rv0, rv1;

  assign owner_rdy = owner_q ? bus.i_p1_resp_ready
                             : bus.i_p0_resp_ready;

  // A slot opens when nothing is held or the held
  // response is consumed this very cycle.
  assign can_gnt = !i_sys_rst &&
                   ((state_q == IDLE) || owner_rdy);

  // rr_q names the port that wins a tie.
  assign gnt0 = can_gnt && bus.i_p0_req_valid &&
                (!bus.i_p1_req_valid || !rr_q);
  assign gnt1 = can_gnt && bus.i_p1_req_valid &&
                (!bus.i_p0_req_valid || rr_q);
  assign gnt  = gnt0 | gnt1;

  assign gaddr = gnt1 ? bus.i_p1_req_addr
                      : bus.i_p0_req_addr;
  assign gword = {2'b00, gaddr[ADDR_W-1:2]};
  assign bad   = (gaddr[1:0] != 2'b00) ||
                 (gword >= LIMIT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q;
    data_d  = data_q;
    if (gnt) begin
      state_d = RESP;
      owner_d = gnt1;
      rr_d    = gnt0;
      err_d   = bad;
      data_d  = bad ? '0 : bus.i_rom_rd_data;
    end else if (state_q == RESP && owner_rdy) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign rv0 = (state_q == RESP) && !owner_q;
  assign rv1 = (state_q == RESP) &&  owner_q;

  assign bus.o_p0_req_ready  = gnt0;
  assign bus.o_p1_req_ready  = gnt1;
  assign bus.o_rom_rd_en     = gnt && !bad;
  assign bus.o_rom_rd_addr   = (gnt && !bad) ? gaddr : '0;

  assign bus.o_p0_resp_valid = rv0;
  assign bus.o_p0_resp_data  = rv0 ? data_q : '0;
  assign bus.o_p0_resp_err   = rv0 & err_q;
  assign bus.o_p1_resp_valid = rv1;
  assign bus.o_p1_resp_data  = rv1 ? data_q : '0;
  assign bus.o_p1_resp_err   = rv1 & err_q;

endmodule

// File: tb/tb_rom_arb.sv
// Bench for rom_arb: directed vector table plus random traffic
// against a behavioural model of the arbiter.
module tb_rom_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 16;

  typedef struct {
    logic        rst, v0, r0, v1, r1;
    logic [31:0] a0, a1;
  } in_t;

  typedef struct {
    logic        rdy0, rdy1, en;
    logic [31:0] addr;
    logic        rv0, e0, rv1, e1;
    logic [31:0] d0, d1;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rom_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_arb #(.ADDR_W(AW), .DATA_W(DW), .ROM_WORDS(RW)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus.slave)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h5EED_0001 ^ ((a >> 2) * 32'h0001_0101);
  endfunction

  assign bus.i_rom_rd_data = rom(bus.o_rom_rd_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= RW);
  endfunction

  function automatic vec_t mk(
    input logic rs, v0, input logic [31:0] a0, input logic r0,
    input logic v1, input logic [31:0] a1, input logic r1,
    input logic y0, y1, en, input logic [31:0] ad,
    input logic q0, input logic [31:0] d0, input logic e0,
    input logic q1, input logic [31:0] d1, input logic e1);
    vec_t t;
    t.i = '{rst:rs, v0:v0, r0:r0, v1:v1, r1:r1, a0:a0, a1:a1};
    t.o = '{rdy0:y0, rdy1:y1, en:en, addr:ad,
            rv0:q0, e0:e0, rv1:q1, e1:e1, d0:d0, d1:d1};
    return t;
  endfunction

  task automatic chk(input string tag, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %h want %h", tag, nm, act, exp);
    end
  endtask

  task automatic run(input in_t x, input out_t e,
                     input string tag);
    rst                 = x.rst;
    bus.i_p0_req_valid  = x.v0;
    bus.i_p0_req_addr   = x.a0;
    bus.i_p0_resp_ready = x.r0;
    bus.i_p1_req_valid  = x.v1;
    bus.i_p1_req_addr   = x.a1;
    bus.i_p1_resp_ready = x.r1;
    @(negedge clk);
    chk(tag, "p0_req_ready", 32'(bus.o_p0_req_ready), 32'(e.rdy0));
    chk(tag, "p1_req_ready", 32'(bus.o_p1_req_ready), 32'(e.rdy1));
    chk(tag, "rom_rd_en", 32'(bus.o_rom_rd_en), 32'(e.en));
    // address is unconstrained only in an erroneous grant
    if (e.en || !(e.rdy0 || e.rdy1))
      chk(tag, "rom_rd_addr", bus.o_rom_rd_addr, e.addr);
    chk(tag, "p0_resp_valid", 32'(bus.o_p0_resp_valid), 32'(e.rv0));
    chk(tag, "p0_resp_data", bus.o_p0_resp_data, e.d0);
    chk(tag, "p0_resp_err", 32'(bus.o_p0_resp_err), 32'(e.e0));
    chk(tag, "p1_resp_valid", 32'(bus.o_p1_resp_valid), 32'(e.rv1));
    chk(tag, "p1_resp_data", bus.o_p1_resp_data, e.d1);
    chk(tag, "p1_resp_err", 32'(bus.o_p1_resp_err), 32'(e.e1));
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: at most one held response and a tie-winner.
  bit          m_has;
  int          m_own;
  logic [31:0] m_data;
  bit          m_err;
  int          m_ptr;

  function automatic int winner(input in_t x);
    bit freed;
    freed = !m_has || (m_own == 0 ? x.r0 : x.r1);
    if (x.rst || !freed) return -1;
    if (x.v0 && x.v1) return m_ptr;
    if (x.v0) return 0;
    if (x.v1) return 1;
    return -1;
  endfunction

  function automatic out_t predict(input in_t x);
    out_t        o;
    int          w;
    logic [31:0] a;
    o = '{default: '0};
    w = winner(x);
    a = (w == 1) ? x.a1 : x.a0;
    o.rdy0 = (w == 0);
    o.rdy1 = (w == 1);
    if (w >= 0 && !is_bad(a)) begin
      o.en   = 1'b1;
      o.addr = a;
    end
    if (m_has && m_own == 0) begin
      o.rv0 = 1'b1; o.d0 = m_data; o.e0 = m_err;
    end
    if (m_has && m_own == 1) begin
      o.rv1 = 1'b1; o.d1 = m_data; o.e1 = m_err;
    end
    return o;
  endfunction

  task automatic advance(input in_t x);
    int          w;
    logic [31:0] a;
    w = winner(x);
    a = (w == 1) ? x.a1 : x.a0;
    if (x.rst) begin
      m_has = 0; m_own = 0; m_ptr = 0;
      m_data = '0; m_err = 0;
    end else if (w >= 0) begin
      m_has  = 1;
      m_own  = w;
      m_err  = is_bad(a);
      m_data = m_err ? 32'h0 : rom(a);
      m_ptr  = 1 - w;
    end else if (m_has && (m_own == 0 ? x.r0 : x.r1)) begin
      m_has = 0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, RW - 1) * 4);
      2:       return 32'($urandom_range(0, 63) * 4 +
                              $urandom_range(1, 3));
      default: return 32'(RW * 4 + $urandom_range(0, 15) * 4);
    endcase
  endfunction

  vec_t tbl[22];

  initial begin
    in_t  x;
    out_t e;
    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = mk(1, 1,'h10,1, 1,'h14,1, 0,0,0,0,
                 0,0,0, 0,0,0);
    tbl[1]  = mk(0, 1,'h10,1, 0,0,1, 1,0,1,'h10,
                 0,0,0, 0,0,0);
    tbl[2]  = mk(0, 0,0,1, 0,0,1, 0,0,0,0,
                 1,rom('h10),0, 0,0,0);
    tbl[3]  = mk(0, 0,0,1, 0,0,1, 0,0,0,0,
                 0,0,0, 0,0,0);
    tbl[4]  = mk(1, 0,0,1, 0,0,1, 0,0,0,0,
                 0,0,0, 0,0,0);
    tbl[5]  = mk(0, 1,4,1, 1,8,1, 1,0,1,4,
                 0,0,0, 0,0,0);
    tbl[6]  = mk(0, 1,4,1, 1,8,1, 0,1,1,8,
                 1,rom(4),0, 0,0,0);
    tbl[7]  = mk(0, 1,4,1, 1,8,1, 1,0,1,4,
                 0,0,0, 1,rom(8),0);
    tbl[8]  = mk(0, 1,4,1, 1,8,1, 0,1,1,8,
                 1,rom(4),0, 0,0,0);
    tbl[9]  = mk(0, 0,0,1, 0,0,1, 0,0,0,0,
                 0,0,0, 1,rom(8),0);
    tbl[10] = mk(0, 0,0,1, 1,6,1, 0,1,0,0,
                 0,0,0, 0,0,0);
    tbl[11] = mk(0, 0,0,1, 1,RW*4,1, 0,1,0,0,
                 0,0,0, 1,0,1);
    tbl[12] = mk(0, 0,0,1, 0,0,1, 0,0,0,0,
                 0,0,0, 1,0,1);
    tbl[13] = mk(0, 1,'h20,0, 0,0,1, 1,0,1,'h20,
                 0,0,0, 0,0,0);
    tbl[14] = mk(0, 0,0,0, 1,'hC,1, 0,0,0,0,
                 1,rom('h20),0, 0,0,0);
    tbl[15] = tbl[14];
    tbl[16] = tbl[14];
    tbl[17] = mk(0, 0,0,1, 1,'hC,1, 0,1,1,'hC,
                 1,rom('h20),0, 0,0,0);
    tbl[18] = mk(0, 1,'h24,0, 0,0,1, 1,0,1,'h24,
                 0,0,0, 1,rom('hC),0);
    tbl[19] = mk(1, 1,0,0, 1,4,0, 0,0,0,0,
                 1,rom('h24),0, 0,0,0);
    tbl[20] = mk(0, 1,0,0, 1,4,0, 1,0,1,0,
                 0,0,0, 0,0,0);
    tbl[21] = mk(0, 0,0,1, 0,0,1, 0,0,0,0,
                 1,rom(0),0, 0,0,0);

    rst = 1'b1;
    bus.i_p0_req_valid  = 1'b0;
    bus.i_p0_req_addr   = '0;
    bus.i_p0_resp_ready = 1'b0;
    bus.i_p1_req_valid  = 1'b0;
    bus.i_p1_req_addr   = '0;
    bus.i_p1_resp_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 22; k++)
      run(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

    m_has = 0; m_own = 0; m_ptr = 0;
    m_data = '0; m_err = 0;
    for (int k = 0; k < 400; k++) begin
      x.rst = (k == 0) || ($urandom_range(0, 39) == 0);
      x.v0  = ($urandom_range(0, 2) != 0);
      x.v1  = ($urandom_range(0, 2) != 0);
      x.r0  = ($urandom_range(0, 3) != 0);
      x.r1  = ($urandom_range(0, 3) != 0);
      x.a0  = rand_addr();
      x.a1  = rand_addr();
      e = predict(x);
      run(x, e, $sformatf("rnd%0d", k));
      advance(x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arb.md
ROM_ARB -- requirements
Module: rom_arb

Interface
REQ-001 Parameter ADDR_W, default 32, width of request addresses and ROM read address.
REQ-002 Parameter DATA_W, default 32, width of ROM read data and response data.
REQ-003 Parameter ROM_WORDS, default 1024, ROM depth in 32-bit words; word-address span for the range check.
REQ-004 i_sys_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_sys_rst  input  1  reset, synchronous, active-high.
REQ-006 i_p0_req_valid  input  1  port 0 (fetch) request valid.
REQ-007 i_p0_req_addr  input  ADDR_W  port 0 byte address.
REQ-008 o_p0_req_ready  output  1  port 0 request accepted this cycle.
REQ-009 o_p0_resp_valid  output  1  port 0 response valid.
REQ-010 i_p0_resp_ready  input  1  port 0 consumes response.
REQ-011 o_p0_resp_data  output  DATA_W  port 0 read data.
REQ-012 o_p0_resp_err  output  1  port 0 access error flag.
REQ-013 i_p1_req_valid, i_p1_req_addr, o_p1_req_ready, o_p1_resp_valid, i_p1_resp_ready, o_p1_resp_data, o_p1_resp_err: port 1 (debug/loader), same directions, widths and meanings as port 0.
REQ-014 o_rom_rd_en  output  1  ROM read enable.
REQ-015 o_rom_rd_addr  output  ADDR_W  ROM byte address.
REQ-016 i_rom_rd_data  input  DATA_W  ROM combinational read data.

Function
REQ-017 The block SHALL implement a two-state FSM: IDLE (no response held) and RESP (one response held for owner port).
REQ-018 A grant SHALL be possible when state is IDLE, or state is RESP and the owner's resp_ready is 1 in the same cycle (back-to-back, one access per cycle sustained).
REQ-019 When a grant is possible and exactly one port has req_valid=1, that port SHALL be granted.
REQ-020 When both ports have req_valid=1, the port selected by a 1-bit round-robin pointer SHALL be granted; after any grant the pointer SHALL point to the non-granted port.
REQ-021 In a grant cycle, req_ready SHALL be 1 for the granted port only; req_ready SHALL be 0 for both ports in all other cycles, combinationally derived (no dependence of req_ready on req_valid of the same port beyond arbitration).
REQ-022 An address SHALL be erroneous if addr[1:0] != 0 or addr[ADDR_W-1:2] >= ROM_WORDS.
REQ-023 In a grant cycle with a legal address, o_rom_rd_en SHALL be 1, o_rom_rd_addr SHALL equal the granted address, and i_rom_rd_data SHALL be registered into the response data register at the clock edge.
REQ-024 In a grant cycle with an erroneous address, o_rom_rd_en SHALL be 0, response data SHALL be registered as 0 and response err as 1.
REQ-025 Outside grant cycles o_rom_rd_en SHALL be 0 and o_rom_rd_addr SHALL be 0.
REQ-026 Response latency SHALL be exactly one cycle: resp_valid of the granted port asserts on the cycle after the grant.
REQ-027 In RESP, resp_valid, resp_data and resp_err of the owner SHALL be held stable until the owner's resp_ready is 1; the non-owner's resp_valid SHALL be 0 and its data/err outputs 0.
REQ-028 In RESP with owner resp_ready=1 and no grant, the FSM SHALL return to IDLE; with a grant it SHALL stay in RESP with the new owner and new data.
REQ-029 resp_ready while resp_valid=0 SHALL have no effect.
REQ-030 A requester whose req_valid drops without being granted SHALL leave no state change.

Reset
REQ-031 With i_sys_rst=1 at a rising edge, the FSM SHALL go to IDLE, the round-robin pointer to port 0, response data/err/owner registers to 0.
REQ-032 During and after reset until the first grant, all resp_valid, resp_data, resp_err outputs SHALL be 0; a reset asserted in RESP SHALL discard the held response without handshake.
REQ-033 Grants SHALL not occur in a cycle where i_sys_rst=1 (req_ready=0, o_rom_rd_en=0).

Verification
REQ-034 Port 0 alone requests addr 0x10, resp_ready=1 -> cycle N req_ready=1, rom_rd_en=1, rom_rd_addr=0x10; cycle N+1 p0 resp_valid=1, data = ROM word 4, err=0.
REQ-035 Both ports request continuously after reset, resp_ready=1 -> grants alternate p0,p1,p0,p1 one per cycle, responses alternate likewise.
REQ-036 P1 requests 0x0000_0006 -> rom_rd_en=0 in grant cycle; next cycle p1 resp_valid=1, data=0, err=1; same for addr ROM_WORDS*4.
REQ-037 P0 response held with resp_ready=0 for 3 cycles while p1 requests -> p1 req_ready=0, p0 data stable; on p0 resp_ready=1, p1 granted that same cycle.
REQ-038 Reset asserted in RESP with resp_ready=0 -> next cycle state IDLE, all resp_valid=0, pointer at port 0 (both request -> p0 granted first).
